// File: rtl/uart_tx.sv
// FIFO-fed UART transmitter.
// Frame: start, LSB-first data, optional parity, stop.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]  reload_q, reload_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;

    // Baud counter counts down to zero; zero marks the last cycle of a bit.
    assign bit_end = (baud_cnt_q == '0);

    // Next-state, counters and the registered value of the serial line.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        reload_d   = reload_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A divisor of 0 behaves like 1: reload value 0.
                if (baud_div == '0) begin
                    reload_d = '0;
                end else begin
                    reload_d = baud_div - DIV_WIDTH'(1);
                end
                shreg_d    = fifo_dout;
                par_en_d   = parity_en;
                par_bit_d  = (^fifo_dout) ^ parity_odd;
                baud_cnt_d = reload_d;
                bit_cnt_d  = '0;
                state_d    = START;
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = reload_q;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = reload_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shreg_d   = shreg_q >> 1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = reload_q;
                    state_d    = STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so tx is a flop.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    // All state flops; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            reload_q   <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            reload_q   <= reload_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign tx_done    = (state_q == STOP) && bit_end;
    assign fifo_rd_en = rst_n && (state_q == IDLE) && !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model plus a frame-level
// reference waveform, compared cycle by cycle.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fq[$];
    logic l_tx[$], l_busy[$], l_rd[$], l_done[$];
    logic e_tx[$], e_busy[$], e_rd[$], e_done[$];

    uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // One clock: sample at negedge, then model the registered FIFO.
    task automatic tick();
        logic rd;
        @(negedge clk);
        l_tx.push_back(tx);
        l_busy.push_back(busy);
        l_rd.push_back(fifo_rd_en);
        l_done.push_back(tx_done);
        rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_all();
        l_tx.delete(); l_busy.delete(); l_rd.delete(); l_done.delete();
        e_tx.delete(); e_busy.delete(); e_rd.delete(); e_done.delete();
    endtask

    task automatic put(input logic t, input logic b, input logic r, input logic d);
        e_tx.push_back(t);
        e_busy.push_back(b);
        e_rd.push_back(r);
        e_done.push_back(d);
    endtask

    // Reference: IDLE + FETCH cycles, then each bit held for the period.
    task automatic add_frame(input logic [7:0] d, input int div,
                             input bit pen, input bit podd);
        int per;
        logic bits[$];
        per = (div == 0) ? 1 : div;
        put(1'b1, 1'b0, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0, 1'b0);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back((^d) ^ podd);
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++)
            for (int r = 0; r < per; r++)
                put(bits[k], 1'b1, 1'b0, (k == bits.size() - 1) && (r == per - 1));
    endtask

    task automatic add_tail();
        for (int i = 0; i < 4; i++) put(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_outs got %b want 1000", {tx, busy, fifo_rd_en, tx_done});
        end
        push(8'h5A);
        #1;
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd_en got %b want 0", fifo_rd_en);
        end
        tick();
        tick();
        n_cmp++;
        if (fq.size() != 1) begin
            n_err++;
            $display("FAIL reset_no_pop got %0d entries want 1", fq.size());
        end
        fq.delete();
        fifo_empty = 1'b1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        clear_all();
        for (int i = 0; i < 100; i++) tick();
        for (int i = 0; i < 100; i++) begin
            n_cmp++;
            if ({l_tx[i], l_busy[i], l_rd[i]} !== 3'b100) begin
                n_err++;
                $display("FAIL idle cyc %0d tx/busy/rd got %b%b%b want 100",
                         i, l_tx[i], l_busy[i], l_rd[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] dv[4] = '{8'h55, 8'h55, 8'h55, 8'h07};
        bit pe[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bit po[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic want_par[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int shown;
        for (int c = 0; c < 4; c++) begin
            clear_all();
            shown = 0;
            baud_div = 16'd4;
            parity_en = pe[c];
            parity_odd = po[c];
            add_frame(dv[c], 4, pe[c], po[c]);
            add_tail();
            push(dv[c]);
            for (int i = 0; i < e_tx.size(); i++) tick();
            for (int i = 0; i < e_tx.size(); i++) begin
                n_cmp++;
                if ({l_tx[i], l_busy[i], l_rd[i], l_done[i]} !==
                    {e_tx[i], e_busy[i], e_rd[i], e_done[i]}) begin
                    n_err++;
                    if (shown++ < 4)
                        $display("FAIL basic%0d cyc %0d got %b%b%b%b want %b%b%b%b",
                                 c, i, l_tx[i], l_busy[i], l_rd[i], l_done[i],
                                 e_tx[i], e_busy[i], e_rd[i], e_done[i]);
                end
            end
            // Bit after data (index 39): parity or stop level.
            n_cmp++;
            if (l_tx[39] !== want_par[c]) begin
                n_err++;
                $display("FAIL basic%0d parity_bit got %b want %b", c, l_tx[39], want_par[c]);
            end
        end
    endtask

    task automatic test_div0();
        int shown = 0;
        clear_all();
        baud_div = 16'd0;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        add_frame(8'hFF, 0, 1'b0, 1'b0);
        add_tail();
        push(8'hFF);
        for (int i = 0; i < e_tx.size(); i++) tick();
        for (int i = 0; i < e_tx.size(); i++) begin
            n_cmp++;
            if ({l_tx[i], l_busy[i], l_rd[i], l_done[i]} !==
                {e_tx[i], e_busy[i], e_rd[i], e_done[i]}) begin
                n_err++;
                if (shown++ < 4)
                    $display("FAIL div0 cyc %0d got %b%b%b%b want %b%b%b%b",
                             i, l_tx[i], l_busy[i], l_rd[i], l_done[i],
                             e_tx[i], e_busy[i], e_rd[i], e_done[i]);
            end
        end
        n_cmp++;
        if ({l_tx[2], l_tx[3], l_done[11], l_busy[12]} !== 4'b0110) begin
            n_err++;
            $display("FAIL div0_frame10 got %b want 0110",
                     {l_tx[2], l_tx[3], l_done[11], l_busy[12]});
        end
    endtask

    task automatic test_back_to_back();
        int shown = 0;
        clear_all();
        baud_div = 16'd2;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        add_frame(8'hA3, 2, 1'b0, 1'b0);
        add_frame(8'h3C, 2, 1'b0, 1'b0);
        add_tail();
        push(8'hA3);
        push(8'h3C);
        for (int i = 0; i < e_tx.size(); i++) tick();
        for (int i = 0; i < e_tx.size(); i++) begin
            n_cmp++;
            if ({l_tx[i], l_busy[i], l_rd[i], l_done[i]} !==
                {e_tx[i], e_busy[i], e_rd[i], e_done[i]}) begin
                n_err++;
                if (shown++ < 4)
                    $display("FAIL b2b cyc %0d got %b%b%b%b want %b%b%b%b",
                             i, l_tx[i], l_busy[i], l_rd[i], l_done[i],
                             e_tx[i], e_busy[i], e_rd[i], e_done[i]);
            end
        end
        // First frame ends at 21; gap 22..23; next start at 24.
        n_cmp++;
        if ({l_done[21], l_tx[22], l_tx[23], l_tx[24], l_busy[22], l_busy[23], l_rd[22]}
            !== 7'b1110011) begin
            n_err++;
            $display("FAIL b2b_gap got %b want 1110011",
                     {l_done[21], l_tx[22], l_tx[23], l_tx[24],
                      l_busy[22], l_busy[23], l_rd[22]});
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int div;
        bit pe, po;
        int shown;
        for (int n = 0; n < 8; n++) begin
            clear_all();
            shown = 0;
            d = 8'($urandom);
            div = int'($urandom_range(0, 5));
            pe = 1'($urandom);
            po = 1'($urandom);
            baud_div = 16'(div);
            parity_en = pe;
            parity_odd = po;
            add_frame(d, div, pe, po);
            add_tail();
            push(d);
            for (int i = 0; i < e_tx.size(); i++) begin
                tick();
                // Config changes once the frame is latched must not matter.
                if (i == 3) begin
                    baud_div = 16'($urandom_range(0, 7));
                    parity_en = 1'($urandom);
                    parity_odd = 1'($urandom);
                end
            end
            for (int i = 0; i < e_tx.size(); i++) begin
                n_cmp++;
                if ({l_tx[i], l_busy[i], l_rd[i], l_done[i]} !==
                    {e_tx[i], e_busy[i], e_rd[i], e_done[i]}) begin
                    n_err++;
                    if (shown++ < 4)
                        $display("FAIL rand%0d d=%h div=%0d cyc %0d got %b%b%b%b want %b%b%b%b",
                                 n, d, div, i, l_tx[i], l_busy[i], l_rd[i], l_done[i],
                                 e_tx[i], e_busy[i], e_rd[i], e_done[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int shown = 0;
        clear_all();
        baud_div = 16'd4;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        add_frame(8'h96, 4, 1'b0, 1'b0);
        push(8'h96);
        push(8'hC5);
        // Data bit 3 spans cycles 18..21; stop inside it.
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({l_tx[i], l_busy[i], l_rd[i], l_done[i]} !==
                {e_tx[i], e_busy[i], e_rd[i], e_done[i]}) begin
                n_err++;
                if (shown++ < 4)
                    $display("FAIL midrst_pre cyc %0d got %b%b%b%b want %b%b%b%b",
                             i, l_tx[i], l_busy[i], l_rd[i], l_done[i],
                             e_tx[i], e_busy[i], e_rd[i], e_done[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_async got %b want 1000", {tx, busy, fifo_rd_en, tx_done});
        end
        tick();
        tick();
        rst_n = 1'b1;
        clear_all();
        shown = 0;
        add_frame(8'hC5, 4, 1'b0, 1'b0);
        add_tail();
        for (int i = 0; i < e_tx.size(); i++) tick();
        for (int i = 0; i < e_tx.size(); i++) begin
            n_cmp++;
            if ({l_tx[i], l_busy[i], l_rd[i], l_done[i]} !==
                {e_tx[i], e_busy[i], e_rd[i], e_done[i]}) begin
                n_err++;
                if (shown++ < 4)
                    $display("FAIL midrst_next cyc %0d got %b%b%b%b want %b%b%b%b",
                             i, l_tx[i], l_busy[i], l_rd[i], l_done[i],
                             e_tx[i], e_busy[i], e_rd[i], e_done[i]);
            end
        end
    endtask

    initial begin
        baud_div = 16'd4;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = 8'h00;
        #2 rst_n = 1'b0;
        test_reset();
        test_idle();
        test_basic();
        test_div0();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: frame data bits, equal to the TX FIFO data width.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port baud_div  input  DIV_WIDTH  clk cycles per serial bit.
REQ-006 SHALL have port parity_en  input  1  when 1, a parity bit follows the data bits.
REQ-007 SHALL have port parity_odd  input  1  when 1, parity is odd; when 0, parity is even.
REQ-008 SHALL have port fifo_empty  input  1  TX FIFO empty flag.
REQ-009 SHALL have port fifo_rd_en  output  1  TX FIFO read strobe, one cycle per byte.
REQ-010 SHALL have port fifo_dout  input  DATA_WIDTH  TX FIFO registered read data, valid the cycle after fifo_rd_en.
REQ-011 SHALL have port tx  output  1  serial line; idles high.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, START, DATA, PARITY and STOP.
REQ-015 IDLE: SHALL drive fifo_rd_en = !fifo_empty combinationally or registered-equivalently for exactly that cycle, and SHALL move to FETCH when fifo_empty=0.
REQ-016 IDLE: SHALL never assert fifo_rd_en while fifo_empty=1.
REQ-017 FETCH: lasts 1 cycle; SHALL latch fifo_dout into the shift register and latch baud_div, parity_en and parity_odd for the whole frame, then go to START.
REQ-018 Effective bit period SHALL be baud_div cycles, with baud_div=0 treated as 1.
REQ-019 START: tx=0 for one bit period; then go to DATA.
REQ-020 DATA: SHALL shift out DATA_WIDTH bits LSB first, one bit period each.
REQ-021 After the last data bit, SHALL go to PARITY if parity_en was latched as 1, otherwise to STOP.
REQ-022 PARITY: tx = XOR of the data bits, inverted when parity_odd was latched as 1, for one bit period.
REQ-023 STOP: tx=1 for one bit period; tx_done SHALL pulse on the last cycle of the stop bit; then go to IDLE.
REQ-024 tx SHALL be 1 in IDLE and FETCH, and SHALL be driven from a register (glitch-free).
REQ-025 Back-to-back bytes: SHALL leave exactly 2 idle-high cycles (IDLE + FETCH) between a stop bit and the next start bit.
REQ-026 Changes to baud_div or parity inputs mid-frame SHALL take effect on the next frame only.
REQ-027 The bit counter and baud counter SHALL never wrap mid-bit; the baud counter SHALL reload on every bit boundary.

Reset
REQ-028 On rst_n=0, SHALL asynchronously force tx=1, busy=0, fifo_rd_en=0, tx_done=0 and state=IDLE, and SHALL clear all counters.
REQ-029 A reset mid-frame SHALL abandon the byte; after release, SHALL resume with IDLE and the next FIFO entry.

Verification
REQ-030 0x55, baud_div=4, parity_en=0 -> tx: 0 then 1,0,1,0,1,0,1,0 then 1, 4 cycles per bit (40 cycles); one tx_done; one fifo_rd_en.
REQ-031 0x55, even parity -> parity bit 0; 0x55, odd parity -> parity bit 1; 0x07, even parity -> parity bit 1.
REQ-032 FIFO holding 0xA3 and 0x3C, baud_div=2 -> two frames with exactly 2 high cycles between stop and start; 2 rd_en pulses; busy stays high across the gap except the IDLE cycle.
REQ-033 fifo_empty=1 for 100 cycles -> tx=1, busy=0, fifo_rd_en never asserted.
REQ-034 baud_div=0 with 0xFF -> 1-cycle bits (10-cycle frame).
REQ-035 rst_n pulsed low during DATA bit 3 -> tx=1 immediately; no tx_done; next frame starts cleanly from the FIFO head.
